lsu_bus_ctrl: RTL and testbench
===============================

// Module: lsu_bus_ctrl
// PURPOSE
//  Parametrised load/store bus controller between the MEM stage and N_SLV memory-mapped slaves
//  (DMEM, UART, ...). Decodes addr[31:28] against per-slave base nibbles and runs a registered
//  req/ack transaction. Handles byte/half/word sizing, write strobes and load sign/zero extension.
//  Flags misaligned, unmapped and timed-out accesses. Stalls the pipeline until each access completes.
// PARAMETERS
//  DW        32        data/address width (BUS_WIDTH)
//  N_SLV     2         number of slaves
//  SLV_BASE  {4'h8,4'h0} packed N_SLV x 4-bit base nibbles; slave k = SLV_BASE[4k+:4]
//  TIMEOUT   16        max ACCESS cycles without ack before a timeout error (>=2)
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          synchronous active-low reset
//  req_valid  in   1          MEM stage load/store request; held until rsp_valid
//  req_we     in   1          1=store, 0=load
//  req_size   in   2          lsu_size_e: 00 byte, 01 half, 10 word
//  req_uns    in   1          1=zero-extend load (LBU/LHU)
//  req_addr   in   DW         byte address
//  req_wdata  in   DW         store data, right-aligned
//  lsu_stall  out  1          req_valid & ~rsp_valid; pipeline freeze
//  rsp_valid  out  1          one-cycle completion pulse
//  rsp_err    out  2          lsu_err_e: 00 ok, 01 misaligned, 10 unmapped, 11 timeout
//  rsp_rdata  out  DW         extended load data; 0 on store or error
//  sl_sel     out  N_SLV      one-hot slave select
//  sl_we      out  1          write strobe
//  sl_re      out  1          read strobe
//  sl_addr    out  DW         latched address
//  sl_wdata   out  DW         lane-replicated store data
//  sl_wstrb   out  DW/8       byte enables
//  sl_rdata   in   N_SLV*DW   slave read data; slave k = [DW*k+:DW]
//  sl_ack     in   N_SLV      slave completion; sampled only from the selected slave
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, timeout count=0, all outputs 0. Applies mid-transaction;
//   the aborted access produces no rsp_valid. A late ack after reset is ignored.
//  FSM IDLE -> ACCESS | RESP; ACCESS -> RESP; RESP -> IDLE.
//  IDLE: on req_valid, latch the request and decode it.
//   Misaligned = (half & addr[0]) | (word & addr[1:0]!=0). Misaligned goes to RESP with err=01.
//   Unmapped = no base matches. Unmapped goes to RESP with err=10.
//   Misaligned has priority over unmapped. No slave strobe is driven on either error.
//   Multiple base matches: lowest index wins.
//   Otherwise go to ACCESS; count=0.
//  ACCESS: sel[k]=1, we/re per req_we, and addr/wdata/wstrb are driven from registers.
//   Outputs are stable for the whole state.
//   sl_ack[k]=1: capture sl_rdata[k], go to RESP with err=00.
//   Else if count==TIMEOUT-1: go to RESP with err=11.
//   Else count++.
//   Ack and terminal count in the same cycle: ack wins.
//  RESP: rsp_valid=1 for exactly one cycle; sl_* outputs are 0; next state is IDLE.
//   The pipeline advances on this cycle, so IDLE samples the next instruction.
//  Latency: ok access = 3 cycles minimum (accept, ACCESS with ack, RESP); error = 2 cycles.
//  sl_ack while in IDLE/RESP, or from an unselected slave: ignored.
//  Store lanes (lane = addr[1:0]):
//   byte: wdata={4{b}}, wstrb=4'b0001<<lane
//   half: wdata={2{h}}, wstrb=4'b0011<<lane
//   word: wstrb=4'hF
//  Load: select byte/half at lane, sign- or zero-extend per req_uns; word passes through.
//  Extension happens at capture, so rsp_rdata is registered.
// STRUCTURE
//  lsu_pkg: lsu_size_e, lsu_err_e, lsu_state_e (IDLE/ACCESS/RESP), LSU_REGION_MSB=31, LSU_REGION_LSB=28.
//  Sub-module lsu_load_align: combinational lane extract + extend (data, lane, size, uns -> DW).
//  Everything else stays in lsu_bus_ctrl.
// TESTING
//  Reset: rst_n=0 for 2 cycles -> all outputs 0, state IDLE.
//  LB addr 0x0000_0003, slave0 rdata 0x80FF_FF00 acked in the first ACCESS cycle ->
//   rsp_valid in cycle 3, rdata 0xFFFF_FF80, err 00.
//  SH addr 0x8000_0002, wdata 0x0000_BEEF -> sel=2'b10, wdata 0xBEEF_BEEF, wstrb 4'b1100, we=1.
//  LW addr 0x0000_0002 -> err 01, no sel asserted; addr 0x4000_0000 -> err 10.
//  Slave never acks, TIMEOUT=16 -> rsp_valid with err 11 after 16 ACCESS cycles; ack at count 15 -> err 00.
//  rst_n low during ACCESS, then ack -> no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and address-region constants for the load/store bus controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_OK       = 2'b00,
        LSU_MISALIGN = 2'b01,
        LSU_UNMAPPED = 2'b10,
        LSU_TIMEOUT  = 2'b11
    } lsu_err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    localparam int unsigned LSU_REGION_MSB = 31;
    localparam int unsigned LSU_REGION_LSB = 28;

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane extraction with sign/zero extension (byte, half, word).
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] data_i,
    input  logic [1:0]    lane_i,
    input  lsu_size_e     size_i,
    input  logic          uns_i,
    output logic [DW-1:0] data_o
);

    logic [DW-1:0] shifted;

    always_comb begin
        shifted = data_i >> {lane_i, 3'b000};
        unique case (size_i)
            LSU_BYTE: data_o = {{(DW-8){~uns_i & shifted[7]}}, shifted[7:0]};
            LSU_HALF: data_o = {{(DW-16){~uns_i & shifted[15]}}, shifted[15:0]};
            default:  data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: decodes MEM-stage requests onto N_SLV slaves with
// a registered req/ack handshake, sizing, error flagging and pipeline stall.
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned        DW       = 32,
    parameter int unsigned        N_SLV    = 2,
    parameter logic [4*N_SLV-1:0] SLV_BASE = {4'h8, 4'h0},
    parameter int unsigned        TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_uns,
    input  logic [DW-1:0]       req_addr,
    input  logic [DW-1:0]       req_wdata,
    output logic                lsu_stall,
    output logic                rsp_valid,
    output logic [1:0]          rsp_err,
    output logic [DW-1:0]       rsp_rdata,
    output logic [N_SLV-1:0]    sl_sel,
    output logic                sl_we,
    output logic                sl_re,
    output logic [DW-1:0]       sl_addr,
    output logic [DW-1:0]       sl_wdata,
    output logic [DW/8-1:0]     sl_wstrb,
    input  logic [N_SLV*DW-1:0] sl_rdata,
    input  logic [N_SLV-1:0]    sl_ack
);

    localparam int unsigned NB    = DW / 8;
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    lsu_size_e         size_q;
    logic              uns_q;
    logic              we_q;
    logic [1:0]        lane_q;
    logic              rsp_valid_q;
    logic [1:0]        rsp_err_q;
    logic [DW-1:0]     rsp_rdata_q;
    logic [N_SLV-1:0]  sl_sel_q;
    logic              sl_we_q;
    logic              sl_re_q;
    logic [DW-1:0]     sl_addr_q;
    logic [DW-1:0]     sl_wdata_q;
    logic [NB-1:0]     sl_wstrb_q;

    lsu_size_e         req_sz;
    logic              misalign;
    logic              hit;
    logic [N_SLV-1:0]  sel_d;
    logic [DW-1:0]     wdata_d;
    logic [NB-1:0]     wstrb_d;
    logic [DW-1:0]     rd_mux;
    logic [DW-1:0]     ld_data;
    logic              ack_hit;

    // Request decode; lowest-index base match wins when regions overlap.
    always_comb begin
        req_sz   = lsu_size_e'(req_size);
        misalign = ((req_sz == LSU_HALF) && req_addr[0]) ||
                   ((req_sz != LSU_BYTE) && (req_sz != LSU_HALF) && (req_addr[1:0] != 2'b00));
        sel_d = '0;
        hit   = 1'b0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            if (!hit && (req_addr[LSU_REGION_MSB:LSU_REGION_LSB] == SLV_BASE[4*k +: 4])) begin
                sel_d[k] = 1'b1;
                hit      = 1'b1;
            end
        end
        wdata_d = '0;
        wstrb_d = '0;
        if (req_we) begin
            unique case (req_sz)
                LSU_BYTE: begin
                    wdata_d = {NB{req_wdata[7:0]}};
                    wstrb_d = NB'(1) << req_addr[1:0];
                end
                LSU_HALF: begin
                    wdata_d = {(NB/2){req_wdata[15:0]}};
                    wstrb_d = NB'(3) << req_addr[1:0];
                end
                default: begin
                    wdata_d = req_wdata;
                    wstrb_d = '1;
                end
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            if (sl_sel_q[k]) begin
                rd_mux = rd_mux | sl_rdata[DW*k +: DW];
            end
        end
        ack_hit = |(sl_ack & sl_sel_q);
    end

    lsu_load_align #(
        .DW(DW)
    ) u_load_align (
        .data_i (rd_mux),
        .lane_i (lane_q),
        .size_i (size_q),
        .uns_i  (uns_q),
        .data_o (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            size_q      <= LSU_BYTE;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            lane_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= '0;
            rsp_rdata_q <= '0;
            sl_sel_q    <= '0;
            sl_we_q     <= 1'b0;
            sl_re_q     <= 1'b0;
            sl_addr_q   <= '0;
            sl_wdata_q  <= '0;
            sl_wstrb_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        size_q <= req_sz;
                        uns_q  <= req_uns;
                        we_q   <= req_we;
                        lane_q <= req_addr[1:0];
                        cnt_q  <= '0;
                        if (misalign) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= LSU_MISALIGN;
                            rsp_rdata_q <= '0;
                        end else if (!hit) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= LSU_UNMAPPED;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q    <= ST_ACCESS;
                            sl_sel_q   <= sel_d;
                            sl_we_q    <= req_we;
                            sl_re_q    <= ~req_we;
                            sl_addr_q  <= req_addr;
                            sl_wdata_q <= wdata_d;
                            sl_wstrb_q <= wstrb_d;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Ack is tested first so it wins over the terminal count.
                    if (ack_hit || (cnt_q == CNT_LAST)) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ack_hit ? LSU_OK : LSU_TIMEOUT;
                        rsp_rdata_q <= (ack_hit && !we_q) ? ld_data : '0;
                        sl_sel_q    <= '0;
                        sl_we_q     <= 1'b0;
                        sl_re_q     <= 1'b0;
                        sl_addr_q   <= '0;
                        sl_wdata_q  <= '0;
                        sl_wstrb_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= '0;
                    rsp_rdata_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign lsu_stall = req_valid & ~rsp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign sl_sel    = sl_sel_q;
    assign sl_we     = sl_we_q;
    assign sl_re     = sl_re_q;
    assign sl_addr   = sl_addr_q;
    assign sl_wdata  = sl_wdata_q;
    assign sl_wstrb  = sl_wstrb_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: expected responses queued at issue, compared on rsp_valid.
module tb_lsu_bus_ctrl;

    localparam int DW    = 32;
    localparam int N_SLV = 2;
    localparam int TO    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_uns = 1'b0;
    logic [DW-1:0]     req_addr = '0;
    logic [DW-1:0]     req_wdata = '0;
    logic              lsu_stall;
    logic              rsp_valid;
    logic [1:0]        rsp_err;
    logic [DW-1:0]     rsp_rdata;
    logic [N_SLV-1:0]  sl_sel;
    logic              sl_we;
    logic              sl_re;
    logic [DW-1:0]     sl_addr;
    logic [DW-1:0]     sl_wdata;
    logic [DW/8-1:0]   sl_wstrb;
    logic [N_SLV*DW-1:0] sl_rdata = '0;
    logic [N_SLV-1:0]  sl_ack = '0;

    always #5 clk = ~clk;

    lsu_bus_ctrl #(
        .DW       (DW),
        .N_SLV    (N_SLV),
        .SLV_BASE ({4'h8, 4'h0}),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_uns   (req_uns),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .lsu_stall (lsu_stall),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .sl_sel    (sl_sel),
        .sl_we     (sl_we),
        .sl_re     (sl_re),
        .sl_addr   (sl_addr),
        .sl_wdata  (sl_wdata),
        .sl_wstrb  (sl_wstrb),
        .sl_rdata  (sl_rdata),
        .sl_ack    (sl_ack)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [33:0] exp_q[$];
    string       cur_tag = "reset";

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_tag, tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every response must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_rsp", rsp_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_eq("rsp_err", rsp_err, e[33:32]);
                check_eq("rsp_rdata", rsp_rdata, e[31:0]);
            end
        end
    end

    task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                           input int ack_at, input logic [1:0] exp_err, input logic [31:0] exp_rd,
                           input logic [1:0] exp_sel, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_wstrb, input int exp_lat);
        int   cyc;
        int   acc;
        logic done;
        logic seen_sel;
        cur_tag   = tag;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wdata;
        sl_rdata  = exp_sel[1] ? {rd, ~rd} : {~rd, rd};
        exp_q.push_back({exp_err, exp_rd});
        cyc = 1;
        acc = 0;
        done = 1'b0;
        seen_sel = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            sl_ack = '0;
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (cyc == 2) check_eq("stall", lsu_stall, 1'b1);
                if (sl_sel != '0) begin
                    seen_sel = 1'b1;
                    if (acc == 0) begin
                        check_eq("sel", sl_sel, exp_sel);
                        check_eq("we_re", {sl_we, sl_re}, {we, ~we});
                        check_eq("addr", sl_addr, addr);
                        if (we) begin
                            check_eq("wdata", sl_wdata, exp_wdata);
                            check_eq("wstrb", sl_wstrb, exp_wstrb);
                        end
                    end
                    sl_ack = ~exp_sel;
                    if (acc == ack_at) sl_ack = '1;
                    acc++;
                end
            end
        end
        check_eq("completed", done, 1'b1);
        check_eq("latency", cyc, exp_lat);
        if (exp_err == 2'b01 || exp_err == 2'b10) check_eq("no_sel", seen_sel, 1'b0);
        check_eq("stall_rsp", lsu_stall, 1'b0);
        req_valid = 1'b0;
        sl_ack = '0;
        @(negedge clk);
        check_eq("pulse_1cyc", rsp_valid, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_outs",
                 {lsu_stall, rsp_valid, rsp_err, rsp_rdata, sl_sel, sl_we, sl_re, sl_addr, sl_wdata, sl_wstrb},
                 '0);
        rst_n = 1'b1;
        @(negedge clk);

        run_req("lb",   0, 2'b00, 0, 32'h0000_0003, 0, 32'h80FF_FF00, 0, 2'b00, 32'hFFFF_FF80, 2'b01, 0, 0, 3);
        run_req("lbu",  0, 2'b00, 1, 32'h0000_0003, 0, 32'h80FF_FF00, 0, 2'b00, 32'h0000_0080, 2'b01, 0, 0, 3);
        run_req("lh",   0, 2'b01, 0, 32'h8000_0002, 0, 32'h8123_4567, 1, 2'b00, 32'hFFFF_8123, 2'b10, 0, 0, 4);
        run_req("lhu",  0, 2'b01, 1, 32'h8000_0002, 0, 32'h8123_4567, 0, 2'b00, 32'h0000_8123, 2'b10, 0, 0, 3);
        run_req("lw",   0, 2'b10, 0, 32'h8000_0004, 0, 32'hDEAD_BEEF, 3, 2'b00, 32'hDEAD_BEEF, 2'b10, 0, 0, 6);
        run_req("sh",   1, 2'b01, 0, 32'h8000_0002, 32'h0000_BEEF, 32'h1111_1111, 0, 2'b00, 0, 2'b10,
                32'hBEEF_BEEF, 4'b1100, 3);
        run_req("sb",   1, 2'b00, 0, 32'h0000_0001, 32'h1234_5678, 32'h2222_2222, 0, 2'b00, 0, 2'b01,
                32'h7878_7878, 4'b0010, 3);
        run_req("sw",   1, 2'b10, 0, 32'h0000_0010, 32'hCAFE_F00D, 32'h3333_3333, 2, 2'b00, 0, 2'b01,
                32'hCAFE_F00D, 4'b1111, 5);
        run_req("lw_mis",   0, 2'b10, 0, 32'h0000_0002, 0, 32'h4444_4444, 0, 2'b01, 0, 2'b01, 0, 0, 2);
        run_req("lh_mis",   0, 2'b01, 0, 32'h8000_0001, 0, 32'h4444_4444, 0, 2'b01, 0, 2'b10, 0, 0, 2);
        run_req("unmapped", 0, 2'b10, 0, 32'h4000_0000, 0, 32'h5555_5555, 0, 2'b10, 0, 2'b01, 0, 0, 2);
        run_req("mis_prio", 1, 2'b10, 0, 32'h4000_0001, 32'h1, 32'h5555_5555, 0, 2'b01, 0, 2'b01, 0, 0, 2);
        run_req("timeout",  0, 2'b10, 0, 32'h0000_0000, 0, 32'h6666_6666, -1, 2'b11, 0, 2'b01, 0, 0, TO + 2);
        run_req("ack_last", 0, 2'b10, 0, 32'h0000_0008, 0, 32'h7777_7777, TO - 1, 2'b00, 32'h7777_7777,
                2'b01, 0, 0, TO + 2);

        // Reset in the middle of an access, followed by a late ack.
        cur_tag   = "rst_mid";
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h0000_0004;
        sl_rdata  = {32'h0, 32'h9999_9999};
        @(negedge clk);
        check_eq("sel_before_rst", sl_sel, 2'b01);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("outs_in_rst", {rsp_valid, rsp_err, rsp_rdata, sl_sel, sl_we, sl_re, sl_addr}, '0);
        rst_n  = 1'b1;
        sl_ack = '1;
        repeat (3) begin
            @(negedge clk);
            check_eq("no_rsp_after_rst", rsp_valid, 1'b0);
        end
        sl_ack = '0;

        run_req("post_rst", 0, 2'b00, 1, 32'h8000_0001, 0, 32'h00AB_CD00, 0, 2'b00, 32'h0000_00CD, 2'b10, 0, 0, 3);

        repeat (2) @(negedge clk);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
